// File: rtl/except_lane_stage_pkg.sv
// Shared types for the exception-carrying lane stage: the per-lane
// exception pack and the pending-trap FSM state encoding.
package except_lane_stage_pkg;

  typedef struct packed {
    logic        except;
    logic [63:0] epc;
    logic [63:0] ecause;
    logic [63:0] etval;
  } except_pack_t;

  localparam int EXCEPT_PACK_W = $bits(except_pack_t);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } stage_state_t;

  // Older-stage exceptions take precedence over ones found in this stage.
  function automatic except_pack_t except_pick(input except_pack_t prev_p,
                                               input except_pack_t new_p);
    return prev_p.except ? prev_p : new_p;
  endfunction

endpackage

// File: rtl/except_lane_stage_reg.sv
// One lane's registered valid bit and exception pack.
// Priority: rst > flush > stall > load.
module except_lane_reg
  import except_lane_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_stall,
  input  logic         i_load_valid,
  input  except_pack_t i_load_pack,
  output logic         o_valid,
  output except_pack_t o_pack
);

  logic         r_valid;
  except_pack_t r_pack;

  // Lane register: flush clears, stall holds, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pack  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_pack  <= '0;
    end else if (!i_stall) begin
      r_valid <= i_load_valid;
      r_pack  <= i_load_pack;
    end
  end

  assign o_valid = r_valid;
  assign o_pack  = r_pack;

endmodule

// File: rtl/except_lane_stage.sv
// Multi-lane exception stage: merges carried and new exceptions per lane,
// keeps only the oldest excepting lane, squashes younger lanes, and holds a
// pending-trap FSM plus a saturating capture counter.
// Handshake: there is no valid/ready pair; a load happens on every edge
// where stall and flush are both low, and downstream qualifies
// except_happen_o with stall itself.
module except_lane_stage
  import except_lane_stage_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic         [LANES-1:0] valid_i,
  input  except_pack_t [LANES-1:0] except_prev_i,
  input  except_pack_t [LANES-1:0] except_new_i,
  input  logic                     trap_done_i,
  output logic         [LANES-1:0] valid_o,
  output except_pack_t [LANES-1:0] except_o,
  output logic         [LANES-1:0] except_happen_o,
  output logic                     pending_o,
  output logic         [CNT_W-1:0] exc_count_o
);

  except_pack_t [LANES-1:0] w_sel;
  logic         [LANES-1:0] w_lane_exc;
  logic         [LANES-1:0] w_first_oh;
  logic         [LANES-1:0] w_older_exc;
  logic                     w_seen;
  logic                     w_any;
  logic         [LANES-1:0] w_load_valid;
  except_pack_t [LANES-1:0] w_load_pack;
  stage_state_t             r_state;
  stage_state_t             w_state_next;
  logic                     w_capture;
  logic         [CNT_W-1:0] r_cnt;

  // Per-lane source select and oldest-first priority encode.
  always_comb begin
    w_seen      = 1'b0;
    w_sel       = '0;
    w_lane_exc  = '0;
    w_first_oh  = '0;
    w_older_exc = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sel[l]       = except_pick(except_prev_i[l], except_new_i[l]);
      w_lane_exc[l]  = valid_i[l] & w_sel[l].except;
      w_older_exc[l] = w_seen;
      w_first_oh[l]  = w_lane_exc[l] & ~w_seen;
      w_seen         = w_seen | w_lane_exc[l];
    end
    w_any = w_seen;
  end

  // Load values: oldest excepting lane keeps its pack, younger lanes die,
  // and everything is squashed while a trap is pending.
  always_comb begin
    w_load_valid    = '0;
    w_load_pack     = '0;
    except_happen_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (r_state == ST_IDLE && !w_older_exc[l]) begin
        if (w_first_oh[l]) begin
          w_load_valid[l] = 1'b1;
          w_load_pack[l]  = w_sel[l];
        end else begin
          w_load_valid[l] = valid_i[l];
        end
      end
      except_happen_o[l] = w_first_oh[l] & except_new_i[l].except &
                           ~except_prev_i[l].except &
                           (r_state == ST_IDLE) & ~flush;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    except_lane_reg u_lane_reg (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (flush),
      .i_stall      (stall),
      .i_load_valid (w_load_valid[g]),
      .i_load_pack  (w_load_pack[g]),
      .o_valid      (valid_o[g]),
      .o_pack       (except_o[g])
    );
  end

  // Pending-trap state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: capture on an excepting load, release on trap taken or flush.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!flush && !stall && w_any) begin
          w_state_next = ST_PENDING;
          w_capture    = 1'b1;
        end
      end
      ST_PENDING: begin
        if (flush || trap_done_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Saturating count of captures; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (w_capture && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign pending_o   = (r_state == ST_PENDING);
  assign exc_count_o = r_cnt;

endmodule
